// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus producer side.
//   DATA_WIDTH      result value width
//   ROB_TAG_WIDTH   reorder-buffer tag width
//   ZERO_TAG_ROB    null tag; a zero tag means "no result / no broadcast"
//   CDB_FIFO_DEPTH  entries in each per-source result FIFO
package cdb_arbiter_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ROB_TAG_WIDTH  = 4;
  localparam int CDB_FIFO_DEPTH = 4;

  localparam logic [ROB_TAG_WIDTH-1:0] ZERO_TAG_ROB = '0;

  // Source identifiers, also used as the round-robin last-grant encoding.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result FIFO (tag + value) for the CDB arbiter.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i            write tag_i/data_i at the tail (ignored while full)
//   pop_i             drop the head entry (ignored while empty)
//   clear_i           empty the FIFO; overrides push and pop
//   tag_i, data_i     entry to write
//   head_tag_o/_data_o  current head entry
//   empty_o, full_o   occupancy flags, combinational from the count
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int TAG_W  = ROB_TAG_WIDTH,
  parameter int DEPTH  = CDB_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clear_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [TAG_W-1:0]  head_tag_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [TAG_W-1:0]  mem_tag_q  [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = pop_i & ~empty_o & ~clear_i;

  assign head_tag_o  = mem_tag_q[head_q];
  assign head_data_o = mem_data_q[head_q];

  // Pointers are exactly log2(DEPTH) bits, so they wrap naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PTR_W'(1);
      if (do_pop)  head_d = head_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until the count says it is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_tag_q[tail_q]  <= tag_i;
      mem_data_q[tail_q] <= data_i;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Producer-side end of the common data bus. ALU and load/store results are
// buffered in one FIFO each; one FIFO head per cycle is granted and driven
// onto the registered CDB. A zero CDB tag means no broadcast this cycle.
// Build option: define CDB_RR_EN for round-robin arbitration between the two
// FIFOs when both hold entries; otherwise the ALU has fixed priority.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   rdy                        global enable; low freezes all state
//   in_clear                   flush both FIFOs, idle the CDB
//   in_alu_tag/_value          ALU result (tag != 0 marks valid)
//   out_alu_full               ALU FIFO full
//   in_lsb_tag/_value          load/store result (tag != 0 marks valid)
//   out_lsb_full               LSB FIFO full
//   out_cdb_tag/_value         registered broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int TAG_W  = ROB_TAG_WIDTH,
  parameter int DEPTH  = CDB_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_clear,
  input  logic [TAG_W-1:0]  in_alu_tag,
  input  logic [DATA_W-1:0] in_alu_value,
  output logic              out_alu_full,
  input  logic [TAG_W-1:0]  in_lsb_tag,
  input  logic [DATA_W-1:0] in_lsb_value,
  output logic              out_lsb_full,
  output logic [TAG_W-1:0]  out_cdb_tag,
  output logic [DATA_W-1:0] out_cdb_value
);

  localparam logic [TAG_W-1:0] NULL_TAG = TAG_W'(ZERO_TAG_ROB);

  logic              run;
  logic              alu_empty, lsb_empty;
  logic [TAG_W-1:0]  alu_head_tag, lsb_head_tag;
  logic [DATA_W-1:0] alu_head_data, lsb_head_data;
  logic              grant_alu, grant_lsb;
  logic              contended;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;

  // Normal-operation cycle: enabled and not flushing.
  assign run       = rdy & ~in_clear;
  assign contended = ~alu_empty & ~lsb_empty;

  cdb_fifo #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_alu_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (run & (in_alu_tag != NULL_TAG)),
    .pop_i       (run & grant_alu),
    .clear_i     (rdy & in_clear),
    .tag_i       (in_alu_tag),
    .data_i      (in_alu_value),
    .head_tag_o  (alu_head_tag),
    .head_data_o (alu_head_data),
    .empty_o     (alu_empty),
    .full_o      (out_alu_full)
  );

  cdb_fifo #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_lsb_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (run & (in_lsb_tag != NULL_TAG)),
    .pop_i       (run & grant_lsb),
    .clear_i     (rdy & in_clear),
    .tag_i       (in_lsb_tag),
    .data_i      (in_lsb_value),
    .head_tag_o  (lsb_head_tag),
    .head_data_o (lsb_head_data),
    .empty_o     (lsb_empty),
    .full_o      (out_lsb_full)
  );

`ifdef CDB_RR_EN
  // Source granted on the most recent contended cycle; the other one wins
  // the next contention. Uncontended grants leave it untouched.
  cdb_src_e last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= SRC_LSB;
    end else if (run && contended) begin
      last_q <= grant_alu ? SRC_ALU : SRC_LSB;
    end
  end

  always_comb begin
    grant_alu = ~alu_empty;
    grant_lsb = ~lsb_empty;
    if (contended) begin
      grant_alu = (last_q == SRC_LSB);
      grant_lsb = (last_q == SRC_ALU);
    end
  end
`else
  always_comb begin
    grant_alu = ~alu_empty;
    grant_lsb = ~lsb_empty & ~contended;
  end
`endif

  // Idle and flush cycles drive the null tag but keep the last value.
  always_comb begin
    cdb_tag_d   = NULL_TAG;
    cdb_value_d = cdb_value_q;
    if (!in_clear) begin
      if (grant_alu) begin
        cdb_tag_d   = alu_head_tag;
        cdb_value_d = alu_head_data;
      end else if (grant_lsb) begin
        cdb_tag_d   = lsb_head_tag;
        cdb_value_d = lsb_head_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_tag_q   <= NULL_TAG;
      cdb_value_q <= '0;
    end else if (rdy) begin
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  assign out_cdb_tag   = cdb_tag_q;
  assign out_cdb_value = cdb_value_q;

endmodule
